uart_packet_engine: RTL and testbench

- Packet layer directly downstream of the memory manager's UART controller.
- Consumes received bytes from the controller and parses framed write and read commands into byte-wide memory requests.
- Returns responses (ACK/NAK or read data plus checksum) to the controller's transmit side, one byte per handshake.

---
 rtl/uart_packet_engine.sv | 200 ++++++++++++++++++++
 tb/tb_uart_packet_engine.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_engine.sv
// Packet layer between the UART controller and the memory port: parses framed
// write/read commands into byte-wide memory requests and returns ACK/NAK or read data.
module uart_packet_engine #(
  parameter int unsigned TIMEOUT_CYCLES = 32000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned ADDR_WIDTH     = 16
) (
  input  logic                  iClock,
  input  logic                  iReset_n,
  input  logic [7:0]            iRxByte,
  input  logic                  iRxReady,
  input  logic                  iRxError,
  output logic [7:0]            oTxByte,
  output logic                  oTxReady,
  input  logic                  iTxSent,
  output logic [ADDR_WIDTH-1:0] oMemAddr,
  output logic [7:0]            oMemWrData,
  output logic                  oMemWrEn,
  output logic                  oMemRdEn,
  input  logic                  iMemBusy,
  input  logic [7:0]            iMemRdData,
  input  logic                  iMemRdValid,
  output logic                  oBusy,
  output logic                  oPktDone,
  output logic [2:0]            oErrCode
);

  localparam logic [7:0] CmdWr = 8'h57;
  localparam logic [7:0] CmdRd = 8'h52;
  localparam logic [7:0] Ack   = 8'h06;
  localparam logic [7:0] Nak   = 8'h15;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IdleMax = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle, StCmd, StAddrHi, StAddrLo, StLen, StWdata, StChk,
    StRdReq, StRdWait, StRdTx, StResp, StTxWait
  } state_e;

  state_e                r_state, w_state_d;
  logic                  r_is_wr, r_wr_en, r_tx_issued, r_ok;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_wdata, r_xor, r_rd_xor, r_tx_byte;
  logic [8:0]            r_cnt;
  logic [2:0]            r_err;
  logic [TW-1:0]         r_idle_cnt;

  logic w_rx, w_rx_win, w_wr_acc, w_timeout, w_frame, w_overrun, w_cmd_ok;

  // A framing error on the same cycle as a byte discards the byte.
  assign w_rx      = iRxReady && !iRxError;
  assign w_rx_win  = (r_state >= StCmd) && (r_state <= StChk);
  assign w_wr_acc  = r_wr_en && !iMemBusy;
  assign w_timeout = w_rx_win && !iRxReady && (r_idle_cnt == IdleMax);
  assign w_frame   = w_rx_win && iRxError;
  assign w_overrun = w_rx && r_wr_en && !w_wr_acc && (r_state == StWdata || r_state == StChk);
  assign w_cmd_ok  = (iRxByte == CmdWr) || (iRxByte == CmdRd);

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) r_state <= StIdle;
    else           r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_rx && iRxByte == SYNC_BYTE) w_state_d = StCmd;
      StCmd:    if (w_rx) w_state_d = w_cmd_ok ? StAddrHi : StResp;
      StAddrHi: if (w_rx) w_state_d = StAddrLo;
      StAddrLo: if (w_rx) w_state_d = StLen;
      StLen:    if (w_rx) w_state_d = r_is_wr ? StWdata : StChk;
      StWdata: begin
        if (w_rx) begin
          if (w_overrun)          w_state_d = StResp;
          else if (r_cnt == 9'd1) w_state_d = StChk;
        end
      end
      StChk: begin
        if (w_rx) begin
          if (!w_overrun && iRxByte == r_xor && !r_is_wr) w_state_d = StRdReq;
          else                                             w_state_d = StResp;
        end
      end
      StRdReq:  if (!iMemBusy) w_state_d = StRdWait;
      StRdWait: if (iMemRdValid) w_state_d = StRdTx;
      StRdTx:   if (r_tx_issued && iTxSent) w_state_d = (r_cnt == 9'd1) ? StResp : StRdReq;
      StResp:   w_state_d = StTxWait;
      StTxWait: if (iTxSent) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
    if (w_frame || w_timeout) w_state_d = StIdle;
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_is_wr     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_tx_issued <= 1'b0;
      r_ok        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 8'h00;
      r_xor       <= 8'h00;
      r_rd_xor    <= 8'h00;
      r_tx_byte   <= 8'h00;
      r_cnt       <= 9'd0;
      r_err       <= 3'd0;
      r_idle_cnt  <= '0;
    end else begin
      r_tx_issued <= (r_state == StRdTx) && (w_state_d == StRdTx);
      r_idle_cnt  <= (!w_rx_win || iRxReady) ? '0 : r_idle_cnt + TW'(1);
      // Write handshake runs independently of the parser so the last byte can land in CHK.
      if (w_wr_acc) begin
        r_wr_en <= 1'b0;
        r_addr  <= r_addr + ADDR_WIDTH'(1);
      end
      case (r_state)
        StIdle: begin
          if (w_rx && iRxByte == SYNC_BYTE) begin
            r_xor    <= 8'h00;
            r_rd_xor <= 8'h00;
            r_err    <= 3'd0;
            r_ok     <= 1'b0;
          end
        end
        StCmd: begin
          if (w_rx) begin
            r_xor   <= r_xor ^ iRxByte;
            r_is_wr <= (iRxByte == CmdWr);
            if (!w_cmd_ok) begin
              r_err     <= 3'd1;
              r_tx_byte <= Nak;
            end
          end
        end
        StAddrHi: if (w_rx) begin r_addr[15:8] <= iRxByte; r_xor <= r_xor ^ iRxByte; end
        StAddrLo: if (w_rx) begin r_addr[7:0]  <= iRxByte; r_xor <= r_xor ^ iRxByte; end
        StLen:    if (w_rx) begin r_cnt <= {iRxByte == 8'h00, iRxByte}; r_xor <= r_xor ^ iRxByte; end
        StWdata: begin
          if (w_overrun) begin
            r_wr_en   <= 1'b0;
            r_err     <= 3'd3;
            r_tx_byte <= Nak;
          end else if (w_rx) begin
            r_wdata <= iRxByte;
            r_wr_en <= 1'b1;
            r_xor   <= r_xor ^ iRxByte;
            r_cnt   <= r_cnt - 9'd1;
          end
        end
        StChk: begin
          if (w_overrun) begin
            r_wr_en   <= 1'b0;
            r_err     <= 3'd3;
            r_tx_byte <= Nak;
          end else if (w_rx) begin
            if (iRxByte != r_xor) begin
              r_err     <= 3'd2;
              r_tx_byte <= Nak;
            end else if (r_is_wr) begin
              r_tx_byte <= Ack;
              r_ok      <= 1'b1;
            end
          end
        end
        StRdWait: begin
          if (iMemRdValid) begin
            r_tx_byte <= iMemRdData;
            r_rd_xor  <= r_rd_xor ^ iMemRdData;
          end
        end
        StRdTx: begin
          if (r_tx_issued && iTxSent) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
            r_cnt  <= r_cnt - 9'd1;
            if (r_cnt == 9'd1) begin
              r_tx_byte <= r_rd_xor;
              r_ok      <= 1'b1;
            end
          end
        end
        default: ;
      endcase
      if (w_frame)   r_err <= 3'd5;
      if (w_timeout) r_err <= 3'd4;
    end
  end

  always_comb begin
    oBusy      = (r_state != StIdle);
    oTxReady   = (r_state == StResp) || (r_state == StRdTx && !r_tx_issued);
    oTxByte    = r_tx_byte;
    oMemRdEn   = (r_state == StRdReq);
    oMemWrEn   = r_wr_en;
    oMemWrData = r_wdata;
    oMemAddr   = r_addr;
    oPktDone   = (r_state == StTxWait) && iTxSent && r_ok;
    oErrCode   = r_err;
  end

endmodule

// File: tb/tb_uart_packet_engine.sv
// Directed bench for uart_packet_engine: table of whole packets plus hand-written
// sequences for timeout, framing and asynchronous reset mid-transmit.
module tb_uart_packet_engine;

  localparam int unsigned TimeoutCycles = 32000;

  logic        iClock = 1'b0;
  logic        iReset_n = 1'b1;
  logic [7:0]  iRxByte = 8'h00;
  logic        iRxReady = 1'b0;
  logic        iRxError = 1'b0;
  logic [7:0]  oTxByte;
  logic        oTxReady;
  logic        iTxSent = 1'b0;
  logic [15:0] oMemAddr;
  logic [7:0]  oMemWrData;
  logic        oMemWrEn;
  logic        oMemRdEn;
  logic        iMemBusy = 1'b0;
  logic [7:0]  iMemRdData = 8'h00;
  logic        iMemRdValid = 1'b0;
  logic        oBusy;
  logic        oPktDone;
  logic [2:0]  oErrCode;

  uart_packet_engine dut (
    .iClock(iClock), .iReset_n(iReset_n), .iRxByte(iRxByte), .iRxReady(iRxReady),
    .iRxError(iRxError), .oTxByte(oTxByte), .oTxReady(oTxReady), .iTxSent(iTxSent),
    .oMemAddr(oMemAddr), .oMemWrData(oMemWrData), .oMemWrEn(oMemWrEn), .oMemRdEn(oMemRdEn),
    .iMemBusy(iMemBusy), .iMemRdData(iMemRdData), .iMemRdValid(iMemRdValid), .oBusy(oBusy),
    .oPktDone(oPktDone), .oErrCode(oErrCode)
  );

  always #5 iClock = ~iClock;

  typedef struct packed {
    logic [0:7][7:0]  bytes;
    logic [3:0]       nbytes;
    logic             busy;
    logic [0:1][7:0]  rdata;
    logic [0:2][7:0]  tx;
    logic [1:0]       ntx;
    logic [2:0]       err;
    logic             done;
    logic [1:0]       nwr;
    logic [15:0]      wr_addr;
    logic [0:1][7:0]  wr_data;
    logic [1:0]       nrd;
    logic [0:1][15:0] rd_addr;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_log [8];
  logic [15:0] wr_a_log [4];
  logic [7:0]  wr_d_log [4];
  logic [15:0] rd_a_log [4];
  int tx_n, wr_n, rd_n, done_n;
  logic [0:1][7:0] rdata_cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iClock);
      #1;
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 8; i++) tx_log[i] = 8'hxx;
    for (int i = 0; i < 4; i++) begin
      wr_a_log[i] = 16'hxxxx;
      wr_d_log[i] = 8'hxx;
      rd_a_log[i] = 16'hxxxx;
    end
    tx_n = 0; wr_n = 0; rd_n = 0; done_n = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    iRxByte  = b;
    iRxReady = 1'b1;
    tick(1);
    iRxReady = 1'b0;
    tick(4);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (oBusy && k < 5000) begin
      tick(1);
      k++;
    end
    check(name, {63'd0, oBusy}, 64'd0);
    tick(3);
  endtask

  // Transmit side: log each request, acknowledge three cycles later.
  initial forever begin
    @(negedge iClock);
    if (oTxReady) begin
      if (tx_n < 8) tx_log[tx_n] = oTxByte;
      tx_n++;
      tick(3);
      iTxSent = 1'b1;
      tick(1);
      iTxSent = 1'b0;
    end
  end

  // Memory read port: return data two cycles after acceptance.
  initial forever begin
    @(negedge iClock);
    if (oMemRdEn && !iMemBusy) begin
      if (rd_n < 4) rd_a_log[rd_n] = oMemAddr;
      iMemRdData = rdata_cur[rd_n % 2];
      rd_n++;
      tick(2);
      iMemRdValid = 1'b1;
      tick(1);
      iMemRdValid = 1'b0;
    end
  end

  // Accepted writes and completion pulses.
  initial forever begin
    @(negedge iClock);
    if (oMemWrEn && !iMemBusy) begin
      if (wr_n < 4) begin
        wr_a_log[wr_n] = oMemAddr;
        wr_d_log[wr_n] = oMemWrData;
      end
      wr_n++;
    end
    if (oPktDone) done_n++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  vec_t vecs [6];
  vec_t v;

  initial begin
    vecs[0] = '{bytes: {8'hA5, 8'h57, 8'h12, 8'h34, 8'h02, 8'hAA, 8'h55, 8'h8C}, nbytes: 4'd8,
                busy: 1'b0, rdata: {8'h00, 8'h00}, tx: {8'h06, 8'h00, 8'h00}, ntx: 2'd1,
                err: 3'd0, done: 1'b1, nwr: 2'd2, wr_addr: 16'h1234, wr_data: {8'hAA, 8'h55},
                nrd: 2'd0, rd_addr: {16'h0000, 16'h0000}};
    vecs[1] = '{bytes: {8'hA5, 8'h52, 8'hFF, 8'hFF, 8'h02, 8'h50, 8'h00, 8'h00}, nbytes: 4'd6,
                busy: 1'b0, rdata: {8'h11, 8'h22}, tx: {8'h11, 8'h22, 8'h33}, ntx: 2'd3,
                err: 3'd0, done: 1'b1, nwr: 2'd0, wr_addr: 16'h0000, wr_data: {8'h00, 8'h00},
                nrd: 2'd2, rd_addr: {16'hFFFF, 16'h0000}};
    vecs[2] = '{bytes: {8'hA5, 8'h57, 8'h12, 8'h34, 8'h02, 8'hAA, 8'h55, 8'h8D}, nbytes: 4'd8,
                busy: 1'b0, rdata: {8'h00, 8'h00}, tx: {8'h15, 8'h00, 8'h00}, ntx: 2'd1,
                err: 3'd2, done: 1'b0, nwr: 2'd2, wr_addr: 16'h1234, wr_data: {8'hAA, 8'h55},
                nrd: 2'd0, rd_addr: {16'h0000, 16'h0000}};
    vecs[3] = '{bytes: {8'hA5, 8'h43, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, nbytes: 4'd2,
                busy: 1'b0, rdata: {8'h00, 8'h00}, tx: {8'h15, 8'h00, 8'h00}, ntx: 2'd1,
                err: 3'd1, done: 1'b0, nwr: 2'd0, wr_addr: 16'h0000, wr_data: {8'h00, 8'h00},
                nrd: 2'd0, rd_addr: {16'h0000, 16'h0000}};
    vecs[4] = '{bytes: {8'hA5, 8'h57, 8'h12, 8'h34, 8'h02, 8'hAA, 8'h55, 8'h00}, nbytes: 4'd7,
                busy: 1'b1, rdata: {8'h00, 8'h00}, tx: {8'h15, 8'h00, 8'h00}, ntx: 2'd1,
                err: 3'd3, done: 1'b0, nwr: 2'd0, wr_addr: 16'h0000, wr_data: {8'h00, 8'h00},
                nrd: 2'd0, rd_addr: {16'h0000, 16'h0000}};
    vecs[5] = '{bytes: {8'hA5, 8'h57, 8'hFF, 8'hFF, 8'h01, 8'h3C, 8'h6A, 8'h00}, nbytes: 4'd7,
                busy: 1'b0, rdata: {8'h00, 8'h00}, tx: {8'h06, 8'h00, 8'h00}, ntx: 2'd1,
                err: 3'd0, done: 1'b1, nwr: 2'd1, wr_addr: 16'hFFFF, wr_data: {8'h3C, 8'h00},
                nrd: 2'd0, rd_addr: {16'h0000, 16'h0000}};

    clear_logs();
    rdata_cur = {8'h00, 8'h00};
    #1 iReset_n = 1'b0;
    tick(3);
    check("reset_outputs", {24'd0, oTxByte, oTxReady, oMemAddr, oMemWrData, oMemWrEn, oMemRdEn,
                            oBusy, oPktDone, oErrCode}, 64'd0);
    iReset_n = 1'b1;
    tick(2);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      clear_logs();
      iMemBusy  = v.busy;
      rdata_cur = v.rdata;
      for (int b = 0; b < int'(v.nbytes); b++) send_byte(v.bytes[b]);
      wait_idle($sformatf("v%0d_idle", i));
      check($sformatf("v%0d_tx_count", i), 64'(tx_n), 64'(v.ntx));
      for (int t = 0; t < int'(v.ntx); t++)
        check($sformatf("v%0d_tx%0d", i, t), {56'd0, tx_log[t]}, {56'd0, v.tx[t]});
      check($sformatf("v%0d_err", i), {61'd0, oErrCode}, {61'd0, v.err});
      check($sformatf("v%0d_done", i), 64'(done_n), 64'(v.done));
      check($sformatf("v%0d_wr_count", i), 64'(wr_n), 64'(v.nwr));
      for (int w = 0; w < int'(v.nwr); w++) begin
        check($sformatf("v%0d_wr_addr%0d", i, w), {48'd0, wr_a_log[w]},
              {48'd0, 16'(v.wr_addr + 16'(w))});
        check($sformatf("v%0d_wr_data%0d", i, w), {56'd0, wr_d_log[w]}, {56'd0, v.wr_data[w]});
      end
      check($sformatf("v%0d_rd_count", i), 64'(rd_n), 64'(v.nrd));
      for (int r = 0; r < int'(v.nrd); r++)
        check($sformatf("v%0d_rd_addr%0d", i, r), {48'd0, rd_a_log[r]}, {48'd0, v.rd_addr[r]});
      check($sformatf("v%0d_wren_low", i), {63'd0, oMemWrEn}, 64'd0);
      iMemBusy = 1'b0;
    end

    // Inter-byte timeout: still waiting just before the limit, silently idle after it.
    clear_logs();
    send_byte(8'hA5);
    send_byte(8'h57);
    tick(TimeoutCycles - 100);
    check("to_busy_before", {63'd0, oBusy}, 64'd1);
    tick(8000);
    check("to_busy_after", {63'd0, oBusy}, 64'd0);
    check("to_err", {61'd0, oErrCode}, 64'd4);
    check("to_tx_count", 64'(tx_n), 64'd0);

    // Framing error together with a byte: error wins, no response; ignored once idle.
    clear_logs();
    send_byte(8'hA5);
    send_byte(8'h57);
    send_byte(8'h12);
    iRxByte = 8'h34; iRxReady = 1'b1; iRxError = 1'b1;
    tick(1);
    iRxReady = 1'b0; iRxError = 1'b0;
    tick(6);
    check("fr_busy", {63'd0, oBusy}, 64'd0);
    check("fr_err", {61'd0, oErrCode}, 64'd5);
    iRxError = 1'b1;
    tick(1);
    iRxError = 1'b0;
    tick(3);
    check("fr_idle_err_kept", {61'd0, oErrCode}, 64'd5);
    check("fr_tx_count", 64'(tx_n), 64'd0);

    // Asynchronous reset while a read byte waits for iTxSent.
    clear_logs();
    rdata_cur = {8'h11, 8'h22};
    send_byte(8'hA5);
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h01);
    iRxByte = 8'h43; iRxReady = 1'b1;
    tick(1);
    iRxReady = 1'b0;
    for (int k = 0; k < 200 && tx_n == 0; k++) tick(1);
    check("rst_tx_seen", 64'(tx_n), 64'd1);
    check("rst_pre_busy", {63'd0, oBusy}, 64'd1);
    check("rst_pre_addr", {48'd0, oMemAddr}, 64'h0010);
    #2 iReset_n = 1'b0;
    #1;
    check("rst_async_outputs", {24'd0, oTxByte, oTxReady, oMemAddr, oMemWrData, oMemWrEn,
                                oMemRdEn, oBusy, oPktDone, oErrCode}, 64'd0);
    tick(2);
    iReset_n = 1'b1;
    tick(10);
    clear_logs();
    for (int b = 0; b < 8; b++) send_byte(vecs[0].bytes[b]);
    wait_idle("post_rst_idle");
    check("post_rst_tx_count", 64'(tx_n), 64'd1);
    check("post_rst_tx0", {56'd0, tx_log[0]}, 64'h06);
    check("post_rst_done", 64'(done_n), 64'd1);
    check("post_rst_wr_count", 64'(wr_n), 64'd2);
    check("post_rst_wr_addr0", {48'd0, wr_a_log[0]}, 64'h1234);
    check("post_rst_err", {61'd0, oErrCode}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
